// File: rtl/axi_r_arb.sv
// AXI R-channel arbiter: round-robin burst lock, one registered output stage.
// Grants hold until the granted source's last beat is taken.
module axi_r_arb #(
  parameter int N_SRC      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int USER_WIDTH = 1,
  localparam int GW = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [N_SRC-1:0]              rvalid_in,
  output logic [N_SRC-1:0]              rready_in,
  input  logic [N_SRC*ID_WIDTH-1:0]     rid_in,
  input  logic [N_SRC*DATA_WIDTH-1:0]   rdata_in,
  input  logic [N_SRC*4-1:0]            rresp_in,
  input  logic [N_SRC-1:0]              rlast_in,
  input  logic [N_SRC*USER_WIDTH-1:0]   ruser_in,
  output logic                          rvalid,
  input  logic                          rready,
  output logic [ID_WIDTH-1:0]           rid,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic [3:0]                    rresp,
  output logic                          rlast,
  output logic [USER_WIDTH-1:0]         ruser,
  output logic [GW-1:0]                 grant_idx,
  output logic                          burst_active
);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t state, state_nx;

  logic [GW-1:0] rr_ptr, rr_ptr_nx;
  logic [GW-1:0] grant_nx;
  logic [GW-1:0] pick_hi, pick_lo, pick;
  logic          found_hi, found_lo;

  logic                  out_valid;
  logic                  can_load;
  logic                  accept;
  logic [ID_WIDTH-1:0]   g_id;
  logic [DATA_WIDTH-1:0] g_data;
  logic [3:0]            g_resp;
  logic                  g_last;
  logic [USER_WIDTH-1:0] g_user;

  // Lowest requester at/after rr_ptr wins, else lowest overall (wrap).
  always_comb begin
    pick_hi  = '0;
    pick_lo  = '0;
    found_hi = 1'b0;
    found_lo = 1'b0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (rvalid_in[i]) begin
        pick_lo  = GW'(i);
        found_lo = 1'b1;
        if (i >= int'(rr_ptr)) begin
          pick_hi  = GW'(i);
          found_hi = 1'b1;
        end
      end
    end
    pick = found_hi ? pick_hi : pick_lo;
  end

  always_comb begin
    g_id   = '0;
    g_data = '0;
    g_resp = '0;
    g_last = 1'b0;
    g_user = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant_idx == GW'(i)) begin
        g_id   = rid_in[i*ID_WIDTH +: ID_WIDTH];
        g_data = rdata_in[i*DATA_WIDTH +: DATA_WIDTH];
        g_resp = rresp_in[i*4 +: 4];
        g_last = rlast_in[i];
        g_user = ruser_in[i*USER_WIDTH +: USER_WIDTH];
      end
    end
  end

  assign can_load = !out_valid || rready;

  always_comb begin
    rready_in = '0;
    for (int i = 0; i < N_SRC; i++) begin
      rready_in[i] = (state == LOCKED)
                  && (grant_idx == GW'(i))
                  && can_load;
    end
  end

  assign accept = |(rvalid_in & rready_in);

  always_comb begin
    state_nx  = state;
    grant_nx  = grant_idx;
    rr_ptr_nx = rr_ptr;
    unique case (state)
      IDLE: begin
        if (found_lo) begin
          grant_nx = pick;
          state_nx = LOCKED;
        end
      end
      LOCKED: begin
        if (accept && g_last) begin
          state_nx  = IDLE;
          rr_ptr_nx = (grant_idx == GW'(N_SRC - 1))
                    ? '0 : grant_idx + GW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      rr_ptr    <= rr_ptr_nx;
      grant_idx <= grant_nx;
      if (accept)
        out_valid <= 1'b1;
      else if (rready)
        out_valid <= 1'b0;
    end
  end

  // Payload is don't-care while out_valid is low, so no reset.
  always_ff @(posedge aclk) begin
    if (accept) begin
      rid   <= g_id;
      rdata <= g_data;
      rresp <= g_resp;
      rlast <= g_last;
      ruser <= g_user;
    end
  end

  assign rvalid       = out_valid;
  assign burst_active = (state == LOCKED);

endmodule

// File: tb/tb_axi_r_arb.sv
// Bench for axi_r_arb: burst-level source model plus directed scenarios.
// Sampling and model stepping happen on the falling edge.
module tb_axi_r_arb;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int UW = 1;

  logic clk = 1'b0;
  logic areset = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    rvalid_in;
  logic [N-1:0]    rready_in;
  logic [N*IW-1:0] rid_in;
  logic [N*DW-1:0] rdata_in;
  logic [N*4-1:0]  rresp_in;
  logic [N-1:0]    rlast_in;
  logic [N*UW-1:0] ruser_in;
  logic            rvalid;
  logic            rready;
  logic [IW-1:0]   rid;
  logic [DW-1:0]   rdata;
  logic [3:0]      rresp;
  logic            rlast;
  logic [UW-1:0]   ruser;
  logic [1:0]      grant_idx;
  logic            burst_active;

  axi_r_arb #(
    .N_SRC(N), .DATA_WIDTH(DW),
    .ID_WIDTH(IW), .USER_WIDTH(UW)
  ) dut (
    .aclk(clk), .areset(areset),
    .rvalid_in(rvalid_in), .rready_in(rready_in),
    .rid_in(rid_in), .rdata_in(rdata_in),
    .rresp_in(rresp_in), .rlast_in(rlast_in),
    .ruser_in(ruser_in),
    .rvalid(rvalid), .rready(rready),
    .rid(rid), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .ruser(ruser),
    .grant_idx(grant_idx),
    .burst_active(burst_active)
  );

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic [3:0]    resp;
    logic          last;
    logic [UW-1:0] user;
  } beat_t;

  int checks = 0;
  int errors = 0;

  // per-source burst generators
  int          blen [N];
  int          beat [N];
  int          nb   [N];
  logic [31:0] base [N];
  bit          pause[N];

  // expected-behaviour state
  bit    m_locked, m_ov;
  int    m_grant, m_ptr;
  beat_t m_beat;

  int          glog[$];
  logic [31:0] dlog[$];
  int          idlog[$];
  bit          llog[$];
  int          cyc = 0;
  int          first_rv = -1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      rvalid_in[i] = (nb[i] > 0) && !pause[i];
      rid_in[i*IW +: IW]   = IW'(i);
      rdata_in[i*DW +: DW] = base[i] + 32'(beat[i]);
      rresp_in[i*4 +: 4]   = 4'(beat[i] & 3);
      rlast_in[i]          = (beat[i] == blen[i] - 1);
      ruser_in[i*UW +: UW] = UW'(beat[i] & 1);
    end
  endtask

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    r = '0;
    if (m_locked && (!m_ov || rready)) r[m_grant] = 1'b1;
    return r;
  endfunction

  task automatic advance(input int i);
    if (beat[i] == blen[i] - 1) begin
      beat[i] = 0;
      nb[i]   = nb[i] - 1;
      base[i] = base[i] + 32'h10;
    end else begin
      beat[i] = beat[i] + 1;
    end
  endtask

  task automatic tick();
    logic [N-1:0] er;
    bit acc, lst;
    @(negedge clk);
    chk("rvalid", 64'(rvalid), 64'(m_ov));
    if (m_ov)
      chk("payload", 64'({rid, rdata, rresp, rlast, ruser}), 64'(m_beat));
    chk("rready_in", 64'(rready_in), 64'(exp_ready()));
    chk("burst_active", 64'(burst_active), 64'(m_locked));
    chk("grant_idx", 64'(grant_idx), 64'(m_grant));
    er = exp_ready();
    if (areset) begin
      m_locked = 0;
      m_ov     = 0;
      m_grant  = 0;
      m_ptr    = 0;
    end else begin
      if (rvalid && rready) begin
        dlog.push_back(rdata);
        idlog.push_back(int'(rid));
        llog.push_back(rlast);
      end
      if (rvalid && first_rv < 0) first_rv = cyc;
      acc = m_locked && rvalid_in[m_grant] && er[m_grant];
      lst = rlast_in[m_grant];
      if (acc) begin
        m_beat = {rid_in[m_grant*IW +: IW],
                  rdata_in[m_grant*DW +: DW],
                  rresp_in[m_grant*4 +: 4],
                  rlast_in[m_grant],
                  ruser_in[m_grant*UW +: UW]};
        m_ov = 1;
      end else if (m_ov && rready) begin
        m_ov = 0;
      end
      if (!m_locked) begin
        for (int k = 0; k < N; k++) begin
          if (!m_locked && rvalid_in[(m_ptr + k) % N]) begin
            m_grant  = (m_ptr + k) % N;
            m_locked = 1;
            glog.push_back(m_grant);
          end
        end
      end else if (acc && lst) begin
        m_locked = 0;
        m_ptr    = (m_grant + 1) % N;
      end
      for (int i = 0; i < N; i++)
        if (rvalid_in[i] && rready_in[i]) advance(i);
    end
    @(posedge clk);
    cyc++;
    #1 drive();
  endtask

  task automatic clear_logs();
    glog.delete();
    dlog.delete();
    idlog.delete();
    llog.delete();
    first_rv = -1;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    for (int i = 0; i < N; i++) begin
      nb[i] = 0; beat[i] = 0; blen[i] = 1;
      base[i] = '0; pause[i] = 0;
    end
    drive();
    tick();
    tick();
    areset = 1'b0;
    clear_logs();
  endtask

  task automatic run_idle(input int budget, input string nm);
    bit done;
    done = 0;
    for (int c = 0; c < budget && !done; c++) begin
      tick();
      done = !m_ov && !m_locked;
      for (int i = 0; i < N; i++)
        if (nb[i] != 0) done = 0;
    end
    chk({nm, "_timeout"}, 64'(done), 64'd1);
  endtask

  initial begin
    int t0, n;
    rready = 1'b1;
    rvalid_in = '0; rid_in = '0; rdata_in = '0;
    rresp_in = '0; rlast_in = '0; ruser_in = '0;
    do_reset();
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_busy", 64'(burst_active), 64'd0);
    chk("rst_rready_in", 64'(rready_in), 64'd0);
    chk("rst_grant", 64'(grant_idx), 64'd0);

    // single 4-beat burst from source 2
    nb[2] = 1; blen[2] = 4; base[2] = 32'hA0;
    drive();
    t0 = cyc;
    tick();
    chk("s1_grant", 64'(grant_idx), 64'd2);
    chk("s1_busy", 64'(burst_active), 64'd1);
    run_idle(30, "s1");
    chk("s1_latency", 64'(first_rv - t0), 64'd2);
    chk("s1_count", 64'(dlog.size()), 64'd4);
    n = dlog.size();
    for (int j = 0; j < 4 && j < n; j++) begin
      chk("s1_data", 64'(dlog[j]), 64'(32'hA0 + j));
      chk("s1_last", 64'(llog[j]), 64'(j == 3));
    end
    chk("s1_ptr", 64'(m_ptr), 64'd3);

    // all sources, two 2-beat bursts each
    do_reset();
    for (int i = 0; i < N; i++) begin
      nb[i] = 2; blen[i] = 2; base[i] = 32'(i * 256);
    end
    drive();
    run_idle(100, "s2");
    chk("s2_grants", 64'(glog.size()), 64'd8);
    if (glog.size() >= 5) begin
      chk("s2_g0", 64'(glog[0]), 64'd0);
      chk("s2_g1", 64'(glog[1]), 64'd1);
      chk("s2_g2", 64'(glog[2]), 64'd2);
      chk("s2_g3", 64'(glog[3]), 64'd3);
      chk("s2_g4", 64'(glog[4]), 64'd0);
    end
    chk("s2_beats", 64'(idlog.size()), 64'd16);
    n = idlog.size();
    for (int j = 0; j < 10 && j < n; j++)
      chk("s2_order", 64'(idlog[j]), 64'((j / 2) % 4));

    // granted source stalls, other source must wait
    do_reset();
    nb[1] = 1; blen[1] = 4; base[1] = 32'h10;
    drive();
    for (int c = 0; c < 10 && beat[1] < 1; c++) tick();
    chk("s3_started", 64'(beat[1]), 64'd1);
    pause[1] = 1;
    nb[0] = 1; blen[0] = 2; base[0] = 32'h300;
    drive();
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("s3_hold", 64'(grant_idx), 64'd1);
      chk("s3_rdy0", 64'(rready_in[0]), 64'd0);
    end
    pause[1] = 0;
    drive();
    run_idle(40, "s3");
    chk("s3_beats", 64'(idlog.size()), 64'd6);
    n = idlog.size();
    for (int j = 0; j < 6 && j < n; j++)
      chk("s3_order", 64'(idlog[j]), 64'(j < 4 ? 1 : 0));

    // master back-pressure
    do_reset();
    nb[3] = 1; blen[3] = 4; base[3] = 32'h40;
    drive();
    for (int c = 0; c < 10 && !m_ov; c++) tick();
    rready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("s4_rvalid", 64'(rvalid), 64'd1);
      chk("s4_data", 64'(rdata), 64'h40);
      chk("s4_id", 64'(rid), 64'd3);
      chk("s4_last", 64'(rlast), 64'd0);
      chk("s4_rdy", 64'(rready_in[3]), 64'd0);
    end
    rready = 1'b1;
    run_idle(30, "s4");
    chk("s4_count", 64'(dlog.size()), 64'd4);
    n = dlog.size();
    for (int j = 0; j < 4 && j < n; j++)
      chk("s4_seq", 64'(dlog[j]), 64'(32'h40 + j));

    // reset mid-burst
    do_reset();
    nb[2] = 1; blen[2] = 4; base[2] = 32'h50;
    drive();
    for (int c = 0; c < 10 && beat[2] < 2; c++) tick();
    areset = 1'b1;
    for (int i = 0; i < N; i++) nb[i] = 0;
    drive();
    tick();
    chk("s5_rvalid", 64'(rvalid), 64'd0);
    chk("s5_busy", 64'(burst_active), 64'd0);
    chk("s5_rready_in", 64'(rready_in), 64'd0);
    areset = 1'b0;
    clear_logs();
    nb[1] = 1; blen[1] = 2; base[1] = 32'h60; beat[1] = 0;
    nb[3] = 1; blen[3] = 2; base[3] = 32'h70; beat[3] = 0;
    drive();
    run_idle(40, "s5");
    chk("s5_grants", 64'(glog.size()), 64'd2);
    if (glog.size() >= 2) begin
      chk("s5_first", 64'(glog[0]), 64'd1);
      chk("s5_second", 64'(glog[1]), 64'd3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
